uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler that shares the Wishbone UART transmitter between two byte-stream requesters. It arbitrates round-robin with packet locking and acts as a Wishbone master toward the UART slave. For each byte it polls UCR until tx_busy (bit 4) is clear, then writes DATA. It sits between firmware-independent hardware sources (e.g. debug/trace streams) and the UART on the shared Wishbone bus.

## Interface
- uart_base, 32'h00000000, byte address of the UART UCR register; DATA is at uart_base+4
- guard_cycles, 2, idle cycles inserted after each DATA write before the next poll (range 1..15)
- poll_limit, 16'd50000, maximum UCR reads per byte before the byte is dropped (must be ≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has a byte
- req0_data / req1_data  in  8  byte to transmit
- req0_last / req1_last  in  1  byte ends a packet; releases the lock
- req0_ready / req1_ready  out  1  one-cycle pulse: byte accepted this cycle
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master strobes
- wbm_adr_o  out  32  address
- wbm_sel_o  out  4  byte select, always 4'b0001 when stb high
- wbm_dat_o  out  32  write data {24'b0, byte}
- wbm_dat_i  in  32  read data; bit 4 = tx_busy
- wbm_ack_i  in  1  slave acknowledge
- busy  out  1  high whenever the state is not IDLE
- lock_id  out  1  requester currently granted or locked
- locked  out  1  a packet is in progress (last not yet seen)
- drop  out  1  one-cycle pulse when a byte is discarded on poll timeout

## Operation
- States: IDLE, POLL, WAIT_R, WRITE, GUARD.
- IDLE:
  - If locked, only requester lock_id is eligible. Otherwise an eligible requester is any one with valid=1.
  - If both are eligible, grant the one not granted last (rr pointer).
  - On grant: pulse reqN_ready, latch data and last into a holding register, set lock_id=N and locked=~last, update the rr pointer to N, and go to POLL.
  - No valid eligible requester: stay in IDLE.
- POLL: assert cyc, stb and we=0 with adr=uart_base; increment the poll counter. Hold until wbm_ack_i=1.
  - On ack with dat_i[4]=0: go to WRITE.
  - On ack with dat_i[4]=1 and counter<poll_limit: go to WAIT_R, which drops stb/cyc for one cycle and then returns to POLL.
  - On ack with dat_i[4]=1 and counter==poll_limit: pulse drop, clear locked, and go to GUARD.
- WRITE: assert cyc, stb and we=1 with adr=uart_base+4 and dat_o={24'b0,byte}. Hold until ack, then go to GUARD. The poll counter clears on entering WRITE or GUARD.
- GUARD: cyc/stb low for guard_cycles cycles, then IDLE. This covers the UART's registered tx_wr→tx_busy delay, so the next poll never sees a stale not-busy.
- Masters hold stb/cyc/adr/we/dat stable from assertion until the cycle ack is sampled. All Wishbone outputs are registered and go low in the cycle after ack.
- A requester deasserting valid mid-packet does not release the lock; the scheduler waits in IDLE for that requester.
- Drop on timeout releases the lock, so the remainder of that packet restarts arbitration.

## Timing
- Reset values:
  - All wbm_* outputs 0; wbm_sel_o=0.
  - reqN_ready 0, busy 0, drop 0, locked 0, lock_id 0.
  - rr pointer = 1, so req0 wins the first tie.
- Reset mid-transaction: all outputs return to reset values next edge; the latched byte is lost.
- ready pulse lasts exactly one cycle, in the IDLE→POLL transition cycle.
- The UART acks one cycle after stb rises. Best-case per byte (idle UART):
  - 1 grant cycle
  - 2 POLL cycles (stb, ack) plus 1 drop cycle
  - 2 WRITE cycles plus 1 drop cycle
  - guard_cycles
  - This totals 7+guard_cycles = 9 cycles at defaults from ready pulse to the next ready.
- Each busy poll iteration costs 3 cycles (POLL 2 + WAIT_R 1).
- Simultaneous valid on both requesters while unlocked is resolved by the rr pointer in the same cycle.

## Test plan
- Single byte: req0 sends 0x41 with last=1, UART idle.
  - Expect: one read at uart_base, then a write of 0x00000041 at uart_base+4 with sel=0001.
  - Expect: req0_ready pulses once; busy drops after the guard.
- Busy UART: stub returns dat_i[4]=1 for 3 reads.
  - Expect: 4 reads, each separated by ≥1 cycle with stb low, then exactly one write.
- Round-robin: both requesters always valid, all bytes last=1.
  - Expect: grant order req0, req1, req0, req1; data order on DATA writes matches.
- Packet lock: req0 sends bytes A,B,C with last on C; req1 valid throughout.
  - Expect: A,B,C are written before any req1 byte, including while req0 valid drops for 5 cycles between B and C.
- Timeout: poll_limit=4 and the UART is permanently busy.
  - Expect: exactly 4 reads, a drop pulse, no write, locked=0, and the next byte is arbitrated.
- Reset mid-WRITE: assert reset while stb is high.
  - Expect: all outputs are at reset values next cycle; after release, a fresh req0 byte is transmitted normally.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares a Wishbone UART transmitter between two byte-stream requesters.
// Round-robin arbitration with packet locking; per byte it polls UCR until tx_busy
// (bit 4) clears, writes DATA, then idles for a guard interval.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/data/last       requester byte stream (last ends a packet)
//   reqN_ready                 one-cycle accept pulse
//   wbm_*                      Wishbone master toward the UART slave
//   busy                       scheduler not idle
//   lock_id, locked            current/locked requester and packet-in-progress flag
//   drop                       one-cycle pulse when a byte is discarded on poll timeout
module uart_tx_sched #(
    parameter logic [31:0] uart_base    = 32'h0000_0000,
    parameter int unsigned guard_cycles = 2,
    parameter logic [15:0] poll_limit   = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        lock_id,
    output logic        locked,
    output logic        drop
);
    typedef enum logic [2:0] {IDLE, POLL, WAIT_R, WRITE, GUARD} state_t;

    state_t      state, state_n;
    logic        stb_q, stb_n, we_q, we_n;
    logic [7:0]  data_q, data_n;
    logic [15:0] pcnt_q, pcnt_n;
    logic [3:0]  gcnt_q, gcnt_n;
    logic        locked_q, locked_n, lock_id_q, lock_id_n, rr_q, rr_n;
    logic [31:0] adr_q, dat_q;
    logic [3:0]  sel_q;
    logic        elig0, elig1, gnt_id, grant, poll_done, drop_c;
    logic        unused_dat;

    // Only tx_busy matters in the status word.
    assign unused_dat = ^{wbm_dat_i[31:5], wbm_dat_i[3:0]};

    // A locked packet makes only its owner eligible; ties go to the requester not granted last.
    assign elig0     = req0_valid && (!locked_q || !lock_id_q);
    assign elig1     = req1_valid && (!locked_q || lock_id_q);
    assign gnt_id    = (elig0 && elig1) ? ~rr_q : elig1;
    assign grant     = (state == IDLE) && (elig0 || elig1);
    assign poll_done = ({1'b0, pcnt_q} + 17'd1) >= {1'b0, poll_limit};

    always_comb begin
        state_n   = state;
        stb_n     = stb_q;
        we_n      = we_q;
        data_n    = data_q;
        pcnt_n    = pcnt_q;
        gcnt_n    = gcnt_q;
        locked_n  = locked_q;
        lock_id_n = lock_id_q;
        rr_n      = rr_q;
        drop_c    = 1'b0;
        case (state)
            IDLE: if (grant) begin
                state_n   = POLL;
                stb_n     = 1'b1;
                we_n      = 1'b0;
                data_n    = gnt_id ? req1_data : req0_data;
                locked_n  = ~(gnt_id ? req1_last : req0_last);
                lock_id_n = gnt_id;
                rr_n      = gnt_id;
                pcnt_n    = '0;
            end
            POLL: if (wbm_ack_i) begin
                stb_n = 1'b0;
                if (!wbm_dat_i[4]) begin
                    state_n = WRITE;
                    pcnt_n  = '0;
                end else if (poll_done) begin
                    drop_c   = 1'b1;
                    locked_n = 1'b0;
                    state_n  = GUARD;
                    pcnt_n   = '0;
                    gcnt_n   = '0;
                end else begin
                    state_n = WAIT_R;
                    pcnt_n  = pcnt_q + 16'd1;
                end
            end
            WAIT_R: begin
                state_n = POLL;
                stb_n   = 1'b1;
                we_n    = 1'b0;
            end
            // First WRITE cycle is the bus-idle cycle after the poll ack; the strobe rises next.
            WRITE: if (!stb_q) begin
                stb_n = 1'b1;
                we_n  = 1'b1;
            end else if (wbm_ack_i) begin
                stb_n   = 1'b0;
                we_n    = 1'b0;
                state_n = GUARD;
                gcnt_n  = '0;
            end
            // Bus-idle cycle after the ack plus guard_cycles, covering the UART's tx_busy latency.
            GUARD: if (gcnt_q == 4'(guard_cycles)) state_n = IDLE;
                   else gcnt_n = gcnt_q + 4'd1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            data_q    <= '0;
            pcnt_q    <= '0;
            gcnt_q    <= '0;
            locked_q  <= 1'b0;
            lock_id_q <= 1'b0;
            rr_q      <= 1'b1;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
        end else begin
            state     <= state_n;
            stb_q     <= stb_n;
            we_q      <= we_n;
            data_q    <= data_n;
            pcnt_q    <= pcnt_n;
            gcnt_q    <= gcnt_n;
            locked_q  <= locked_n;
            lock_id_q <= lock_id_n;
            rr_q      <= rr_n;
            adr_q     <= stb_n ? (we_n ? uart_base + 32'd4 : uart_base) : '0;
            dat_q     <= (stb_n && we_n) ? {24'b0, data_n} : '0;
            sel_q     <= stb_n ? 4'b0001 : 4'b0000;
        end
    end

    assign req0_ready = grant && !gnt_id && !reset;
    assign req1_ready = grant && gnt_id && !reset;
    assign drop       = drop_c && !reset;
    assign wbm_cyc_o  = stb_q;
    assign wbm_stb_o  = stb_q;
    assign wbm_we_o   = we_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_dat_o  = dat_q;
    assign busy       = state != IDLE;
    assign lock_id    = lock_id_q;
    assign locked     = locked_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched (UART stub, write scoreboard, vector table).
module tb_uart_tx_sched;
    localparam logic [31:0] BASE = 32'h4000_1000;

    logic clk = 0, reset = 1;
    always #5 clk = ~clk;

    logic       r0_valid = 0, r0_last = 0, r1_valid = 0, r1_last = 0, r0_ready, r1_ready;
    logic [7:0] r0_data = 0, r1_data = 0;
    logic       cyc, stb, we, ack = 0, busy, lock_id, locked, drop;
    logic [31:0] adr, dat_o, dat_i = 0;
    logic [3:0] sel;

    uart_tx_sched #(.uart_base(BASE), .guard_cycles(2)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0_valid), .req0_data(r0_data), .req0_last(r0_last), .req0_ready(r0_ready),
        .req1_valid(r1_valid), .req1_data(r1_data), .req1_last(r1_last), .req1_ready(r1_ready),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_sel_o(sel),
        .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
        .busy(busy), .lock_id(lock_id), .locked(locked), .drop(drop));

    // Second instance with a short poll limit against a permanently busy UART.
    logic       t_v0 = 0, t_l0 = 0, t_v1 = 0, t_l1 = 0, t_r0, t_r1;
    logic [7:0] t_d0 = 0, t_d1 = 0;
    logic       t_cyc, t_stb, t_we, t_ack = 0, t_busy, t_lid, t_lck, t_drop;
    logic [31:0] t_adr, t_dato;
    logic [31:0] t_dati = 32'h0000_0010;
    logic [3:0] t_sel;

    uart_tx_sched #(.poll_limit(16'd4)) u_to (
        .clk(clk), .reset(reset),
        .req0_valid(t_v0), .req0_data(t_d0), .req0_last(t_l0), .req0_ready(t_r0),
        .req1_valid(t_v1), .req1_data(t_d1), .req1_last(t_l1), .req1_ready(t_r1),
        .wbm_cyc_o(t_cyc), .wbm_stb_o(t_stb), .wbm_we_o(t_we), .wbm_adr_o(t_adr), .wbm_sel_o(t_sel),
        .wbm_dat_o(t_dato), .wbm_dat_i(t_dati), .wbm_ack_i(t_ack),
        .busy(t_busy), .lock_id(t_lid), .locked(t_lck), .drop(t_drop));

    int cmp_n = 0, err_n = 0, cyc_cnt = 0;
    int n_rd = 0, n_wr = 0, n_rise = 0, rd_bad = 0, wr_chk = 0;
    int rd_base = 0, busy_cfg = 0;
    int t_rd = 0, t_wr = 0, t_drops = 0, t_rd_at_drop = 0;
    logic stb_prev = 0;
    logic [31:0] w_dat[256], w_adr[256];
    logic [3:0]  w_sel[256];
    logic [7:0]  exp_q[$];

    always @(posedge clk) cyc_cnt++;

    // UART stubs: ack one cycle after stb rises; status busy for the first busy_cfg reads.
    always @(posedge clk) begin
        ack   <= stb && !ack;
        dat_i <= (stb && !we && (n_rd - rd_base) < busy_cfg) ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
        t_ack <= t_stb && !t_ack;
    end

    // Bus monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (stb && !stb_prev) n_rise++;
        stb_prev = stb;
        if (cyc && stb && ack) begin
            if (we) begin
                w_dat[n_wr] = dat_o; w_adr[n_wr] = adr; w_sel[n_wr] = sel; n_wr++;
            end else begin
                if (adr !== BASE || sel !== 4'b0001) rd_bad++;
                n_rd++;
            end
        end
        if (t_cyc && t_stb && t_ack) begin
            if (t_we) t_wr++; else t_rd++;
        end
        if (t_drop) begin t_drops++; t_rd_at_drop = t_rd; end
    end

    // Requester drivers: per-item data/last and a count of idle cycles before presenting it.
    logic [7:0] it0_dat[64], it1_dat[64];
    logic       it0_last[64], it1_last[64];
    int         it0_gap[64], it1_gap[64], acc0_t[64];
    int         n0 = 0, n1 = 0, i0 = 0, i1 = 0, gap0 = 0, gap1 = 0;

    always @(negedge clk) begin
        if (i0 < n0 && gap0 < it0_gap[i0]) begin r0_valid = 0; gap0++; end
        else if (i0 < n0) begin r0_valid = 1; r0_data = it0_dat[i0]; r0_last = it0_last[i0]; end
        else r0_valid = 0;
        #2;
        if (r0_valid && r0_ready) begin acc0_t[i0] = cyc_cnt; i0++; gap0 = 0; end
    end

    always @(negedge clk) begin
        if (i1 < n1 && gap1 < it1_gap[i1]) begin r1_valid = 0; gap1++; end
        else if (i1 < n1) begin r1_valid = 1; r1_data = it1_dat[i1]; r1_last = it1_last[i1]; end
        else r1_valid = 0;
        #2;
        if (r1_valid && r1_ready) begin i1++; gap1 = 0; end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_n++;
        if (act !== req) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push0(input logic [7:0] d, input logic l, input int g);
        it0_dat[n0] = d; it0_last[n0] = l; it0_gap[n0] = g; n0++;
    endtask

    task automatic push1(input logic [7:0] d, input logic l, input int g);
        it1_dat[n1] = d; it1_last[n1] = l; it1_gap[n1] = g; n1++;
    endtask

    task automatic wait_wr(input int target, input int lim);
        for (int k = 0; k < lim && n_wr < target; k++) tick();
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (busy && k < 50) begin tick(); k++; end
    endtask

    // Pop one expected byte per logged DATA write and compare payload, address and select.
    task automatic drain(input string tag);
        logic [7:0] e;
        while (wr_chk < n_wr) begin
            if (exp_q.size() == 0) begin
                check({tag, "_extra_wr"}, 32'(n_wr - wr_chk), 0);
                wr_chk = n_wr;
            end else begin
                e = exp_q.pop_front();
                check({tag, "_wr_dat"}, w_dat[wr_chk], {24'h0, e});
                check({tag, "_wr_adr"}, w_adr[wr_chk], BASE + 32'd4);
                check({tag, "_wr_sel"}, 32'(w_sel[wr_chk]), 32'h1);
                wr_chk++;
            end
        end
        check({tag, "_missing_wr"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
        int         busy_reads;
        int         exp_reads;
        int         exp_rises;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int b_rd, b_rise, b0, b1, k, tw;
        logic got;
        vt[0] = '{0, 8'h41, 0, 1, 2};
        vt[1] = '{1, 8'h7E, 0, 1, 2};
        vt[2] = '{0, 8'hC3, 3, 4, 5};
        vt[3] = '{1, 8'h00, 1, 2, 3};
        vt[4] = '{0, 8'hFF, 2, 3, 4};

        repeat (3) tick();
        check("rst_strobes", 32'({cyc, stb, we}), 0);
        check("rst_adr", adr, 0);
        check("rst_dat", dat_o, 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_status", 32'({r0_ready, r1_ready, busy, drop, locked, lock_id}), 0);
        check("rst_to_status", 32'({t_cyc, t_stb, t_busy, t_drop, t_lck, t_lid}), 0);
        reset = 0;
        tick();

        // Single-byte vectors with a configurable number of busy polls.
        for (int i = 0; i < 5; i++) begin
            rd_base = n_rd; busy_cfg = vt[i].busy_reads; b_rd = n_rd; b_rise = n_rise;
            tw = n_wr + 1;
            if (vt[i].id == 0) push0(vt[i].data, 1, 0); else push1(vt[i].data, 1, 0);
            exp_q.push_back(vt[i].data);
            wait_wr(tw, 300);
            wait_idle(k);
            check($sformatf("v%0d_reads", i), 32'(n_rd - b_rd), 32'(vt[i].exp_reads));
            check($sformatf("v%0d_stb_rises", i), 32'(n_rise - b_rise), 32'(vt[i].exp_rises));
            // Write ack cycle is followed by one bus-idle cycle plus two guard cycles.
            check($sformatf("v%0d_guard", i), 32'(k), 3);
            drain($sformatf("v%0d", i));
        end
        check("read_addr_sel", 32'(rd_bad), 0);

        // Back-to-back bytes on an idle UART: 7 + guard_cycles between accepts.
        busy_cfg = 0; b0 = i0; tw = n_wr + 2;
        push0(8'h11, 1, 0); push0(8'h22, 1, 0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        wait_wr(tw, 100);
        wait_idle(k);
        check("ready_gap", 32'(acc0_t[b0 + 1] - acc0_t[b0]), 9);
        drain("b2b");

        // Packet lock: A1,A2,A3 from req0 stay together; req1 waits even while req0 pauses.
        b0 = i0; tw = n_wr + 2;
        push0(8'hA1, 0, 0);
        exp_q.push_back(8'hA1);
        for (k = 0; k < 50 && i0 == b0; k++) tick();
        b1 = i1;
        push1(8'hB9, 1, 0);
        push0(8'hA2, 0, 0);
        push0(8'hA3, 1, 14);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3); exp_q.push_back(8'hB9);
        wait_wr(tw, 100);
        wait_idle(k);
        check("lock_held", 32'({locked, lock_id}), 32'h2);
        check("lock_req1_blocked", 32'(i1 - b1), 0);
        wait_wr(tw + 2, 100);
        wait_idle(k);
        check("lock_released", 32'(locked), 0);
        drain("lock");

        // Round-robin: both always valid; req1 was granted last so req0 leads.
        tw = n_wr + 8;
        for (int j = 0; j < 4; j++) begin
            push0(8'h01 + 8'(j), 1, 0);
            push1(8'h11 + 8'(j), 1, 0);
        end
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back(8'h01 + 8'(j));
            exp_q.push_back(8'h11 + 8'(j));
        end
        wait_wr(tw, 200);
        wait_idle(k);
        drain("rr");

        // Poll timeout on the always-busy instance.
        t_v0 = 1; t_d0 = 8'h33; t_l0 = 0; got = 0;
        for (k = 0; k < 20 && !got; k++) begin #3; if (t_r0) got = 1; tick(); end
        t_v0 = 0;
        check("to_accept0", 32'(got), 1);
        check("to_locked_during", 32'(t_lck), 1);
        for (k = 0; k < 100 && t_drops == 0; k++) tick();
        check("to_reads_at_drop", 32'(t_rd_at_drop), 4);
        tick();
        check("to_unlocked", 32'(t_lck), 0);
        check("to_no_write", 32'(t_wr), 0);
        t_v1 = 1; t_d1 = 8'h44; t_l1 = 1; got = 0;
        for (k = 0; k < 20 && !got; k++) begin #3; if (t_r1) got = 1; tick(); end
        t_v1 = 0;
        check("to_next_arbitrated", 32'(got), 1);
        check("to_drop_pulses", 32'(t_drops), 1);

        // Reset while the DATA write strobe is up.
        busy_cfg = 0;
        push0(8'hE7, 1, 0);
        for (k = 0; k < 50 && !(stb && we); k++) tick();
        check("rst_mid_reached_write", 32'({stb, we}), 32'h3);
        reset = 1;
        tick();
        check("rst_mid_strobes", 32'({cyc, stb, we}), 0);
        check("rst_mid_adr_dat", adr | dat_o, 0);
        check("rst_mid_sel", 32'(sel), 0);
        check("rst_mid_status", 32'({r0_ready, r1_ready, busy, drop, locked, lock_id}), 0);
        reset = 0;
        tw = n_wr;
        repeat (3) tick();
        check("rst_mid_lost_byte", 32'(n_wr - tw), 0);
        // The rr pointer restarts at 1, so req0 takes the first tie.
        push0(8'h5A, 1, 0);
        push1(8'h6B, 1, 0);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h6B);
        wait_wr(tw + 2, 100);
        wait_idle(k);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
